// File: rtl/dadda_mac_accum.sv
// Pipelined multiply-accumulate behind a 16x16 multiplier: groups of LEN products are summed
// and handed off on a valid/ready output. Define DADDA_MAC_SAT_EN for saturating accumulation.
module dadda_mac_accum #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;

  logic [15:0]      a_r, b_r;
  logic             s1_valid, s1_last;
  logic [31:0]      p_r;
  logic             s2_valid, s2_last;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CW-1:0]    cnt;

  logic             stall, accept, beat_last;
  logic [31:0]      prod;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  // Combinational product of the registered operands (the daddamul array's function).
  assign prod = {16'd0, a_r} * {16'd0, b_r};

  // Only a finished group waiting on a busy output can block the pipeline.
  assign stall     = s2_valid & s2_last & out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign beat_last = (cnt == CW'(LEN - 1));

  always_comb begin
    sum_ext  = {1'b0, acc} + {{(ACC_W - 31){1'b0}}, p_r};
    carry    = sum_ext[ACC_W];
    ovf_next = ovf | carry;
`ifdef DADDA_MAC_SAT_EN
    // Once clamped, the rest of the group stays at full scale.
    acc_next = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      p_r       <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (!stall) begin
        s1_valid <= accept;
        s1_last  <= accept & beat_last;
        if (accept) begin
          a_r <= in_a;
          b_r <= in_b;
          cnt <= beat_last ? '0 : cnt + 1'b1;
        end
        s2_valid <= s1_valid;
        s2_last  <= s1_last;
        if (s1_valid) p_r <= prod;
        if (s2_valid) begin
          if (s2_last) begin
            out_sum <= acc_next;
            out_ovf <= ovf_next;
            acc     <= '0;
            ovf     <= 1'b0;
          end else begin
            acc <= acc_next;
            ovf <= ovf_next;
          end
        end
      end
      if (!stall && s2_valid && s2_last) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dadda_mac_accum.sv
// Scoreboard bench for dadda_mac_accum: LEN=4 at ACC_W=40 and 33 on a shared stream, plus a
// LEN=1 instance. Expected sums come from plain integer arithmetic over each group.
module tb_dadda_mac_accum;

  typedef struct packed {
    logic [63:0] s;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        out_ready = 1'b1;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [39:0] out_sum0;
  logic [32:0] out_sum1;
  logic        out_ovf0, out_ovf1;

  logic        l1_valid = 1'b0;
  logic [15:0] l1_a = '0, l1_b = '0;
  logic        l1_oready = 1'b1;
  logic        l1_ready, l1_ovalid, l1_ovf;
  logic [39:0] l1_sum;

  int checks = 0;
  int passes = 0;

  exp_t q0[$], q1[$], q2[$];
  logic [63:0] tot = '0;
  int          beats = 0;
  logic        hold_v = 1'b0;
  logic [39:0] held_sum;
  logic        held_ovf;
  logic        rand_or = 1'b0;

  always #5 clk = ~clk;

  dadda_mac_accum #(.ACC_W(40), .LEN(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0), .out_ovf(out_ovf0)
  );

  dadda_mac_accum #(.ACC_W(33), .LEN(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1), .out_ovf(out_ovf1)
  );

  dadda_mac_accum #(.ACC_W(40), .LEN(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(l1_valid), .in_ready(l1_ready), .in_a(l1_a), .in_b(l1_b),
    .out_valid(l1_ovalid), .out_ready(l1_oready), .out_sum(l1_sum), .out_ovf(l1_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference group result: exact sum, then wrap or clamp at the accumulator width.
  function automatic exp_t model(input logic [63:0] total, input int w);
    exp_t e;
    logic [63:0] maxv;
    maxv = (64'd1 << w) - 64'd1;
    e.o = (total > maxv);
`ifdef DADDA_MAC_SAT_EN
    e.s = e.o ? maxv : total;
`else
    e.s = total & maxv;
`endif
    return e;
  endfunction

  task automatic pop_chk(input string name, inout exp_t q[$], input logic [63:0] s,
                         input logic o);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      $display("FAIL %s_unexpected: got out_valid=1, expected no output", name);
    end else begin
      e = q.pop_front();
      chk({name, "_sum"}, s, e.s);
      chk({name, "_ovf"}, {63'd0, o}, {63'd0, e.o});
    end
  endtask

  // Monitor/scoreboard: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      tot    = '0;
      beats  = 0;
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid0) begin
        chk("hold_sum", {24'd0, out_sum0}, {24'd0, held_sum});
        chk("hold_ovf", {63'd0, out_ovf0}, {63'd0, held_ovf});
      end
      hold_v   = out_valid0 && !out_ready;
      held_sum = out_sum0;
      held_ovf = out_ovf0;
      if (out_valid0 && out_ready) pop_chk("out0", q0, {24'd0, out_sum0}, out_ovf0);
      if (out_valid1 && out_ready) pop_chk("out1", q1, {31'd0, out_sum1}, out_ovf1);
      if (l1_ovalid && l1_oready) pop_chk("len1", q2, {24'd0, l1_sum}, l1_ovf);
      if (in_valid && in_ready0) begin
        tot = tot + 64'(in_a) * 64'(in_b);
        beats++;
        if (beats == 4) begin
          q0.push_back(model(tot, 40));
          q1.push_back(model(tot, 33));
          tot   = '0;
          beats = 0;
        end
      end
      if (l1_valid && l1_ready) q2.push_back(model(64'(l1_a) * 64'(l1_b), 40));
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {63'd0, in_ready0}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && n < 200) begin
      idle(1);
      n++;
    end
    chk("drain_q0_empty", 64'(q0.size()), 64'd0);
    chk("drain_q2_empty", 64'(q2.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_out_sum", {24'd0, out_sum0}, 64'd0);
    chk("rst_out_ovf", {63'd0, out_ovf0}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("rst_len1_ready", {63'd0, l1_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back group, then exact latency and single-cycle valid.
    send(16'd1, 16'd1);
    send(16'd2, 16'd3);
    send(16'd4, 16'd5);
    send(16'd6, 16'd7);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("latency_valid_c%0d", k), {63'd0, out_valid0}, (k == 2) ? 64'd1 : 64'd0);
    end
    idle(1);

    // Largest products: 33-bit instance wraps or clamps.
    repeat (4) send(16'hFFFF, 16'hFFFF);
    drain();

    // Backpressure across two groups.
    out_ready = 1'b0;
    repeat (4) send(16'd1, 16'd1);
    repeat (4) send(16'd2, 16'd2);
    repeat (3) @(negedge clk);
    chk("bp_in_ready_low", {63'd0, in_ready0}, 64'd0);
    chk("bp_out_valid", {63'd0, out_valid0}, 64'd1);
    chk("bp_out_sum", {24'd0, out_sum0}, 64'd4);
    @(posedge clk);
    #1;
    drain();

    // Reset mid-group discards the partial sum.
    send(16'd3, 16'd3);
    send(16'd3, 16'd3);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    repeat (4) send(16'd1, 16'd1);
    drain();

    // Random operands, bubbles and backpressure.
    rand_or = 1'b1;
    fork
      while (rand_or) begin
        out_ready = ($urandom_range(0, 3) != 0);
        idle(1);
      end
    join_none
    for (int i = 0; i < 48; i++) begin
      send(16'($urandom), 16'($urandom));
      idle($urandom_range(0, 2));
    end
    rand_or = 1'b0;
    idle(1);
    drain();

    // LEN=1 with in_valid toggling every other cycle.
    for (int i = 0; i < 8; i++) begin
      l1_valid = 1'b1;
      l1_a = (i == 0) ? 16'd0 : (i == 1) ? 16'd100 : 16'($urandom);
      l1_b = (i == 0) ? 16'd1234 : (i == 1) ? 16'd200 : 16'($urandom);
      idle(1);
      l1_valid = 1'b0;
      idle(1);
    end
    idle(4);
    drain();
    chk("final_q1_empty", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
